// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU opcode values and FSM state encoding.
package exe_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_SLT  = 6;
  localparam int OP_SLTU = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;
  localparam int OP_MUL  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_MUL   = 2'd2,
    ST_MDONE = 2'd3
  } state_e;

endpackage

// File: rtl/exe_alu.sv
// Single-cycle combinational ALU; MUL and unknown opcodes return zero here.
module exe_alu
  import exe_pkg::*;
#(
  parameter int DW  = 32,
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] op,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  output logic [DW-1:0]  y
);

  localparam int SHW = $clog2(DW);

  logic [SHW-1:0] sh;
  assign sh = a[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      OPW'(OP_ADD):  y = a + b;
      OPW'(OP_SUB):  y = a - b;
      OPW'(OP_AND):  y = a & b;
      OPW'(OP_OR):   y = a | b;
      OPW'(OP_XOR):  y = a ^ b;
      OPW'(OP_NOR):  y = ~(a | b);
      OPW'(OP_SLT):  y = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      OPW'(OP_SLTU): y = {{(DW-1){1'b0}}, (a < b)};
      OPW'(OP_SLL):  y = b << sh;
      OPW'(OP_SRL):  y = b >> sh;
      OPW'(OP_SRA):  y = $unsigned($signed(b) >>> sh);
      OPW'(OP_LUI):  y = b << (DW / 2);
      default:       y = '0;
    endcase
  end

endmodule

// File: rtl/exe_pipe.sv
// Execute stage: one-entry instruction slot with valid/ready handshakes,
// a single-cycle ALU and a radix-2 shift-add multiplier.
module exe_pipe
  import exe_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RAW = 5,
  parameter int OPW = 6
) (
  input  logic           i_EXP_clk,
  input  logic           i_EXP_rst,
  input  logic           i_EXP_valid,
  output logic           o_EXP_ready,
  input  logic           i_EXP_flush,
  input  logic [2:0]     i_EXP_ctrl,
  input  logic [2:0]     i_EXP_sel,
  input  logic [RAW-1:0] i_EXP_WRA,
  input  logic [OPW-1:0] i_EXP_ALUop,
  input  logic [DW-1:0]  i_EXP_rd1,
  input  logic [DW-1:0]  i_EXP_rd2,
  input  logic [DW-1:0]  i_EXP_num,
  input  logic [DW-1:0]  i_EXP_shamt,
  output logic           o_EXP_valid,
  input  logic           i_EXP_ready,
  output logic [2:0]     o_EXP_ctrl,
  output logic [RAW-1:0] o_EXP_WRA,
  output logic [DW-1:0]  o_EXP_ALUout,
  output logic [DW-1:0]  o_EXP_rd2
);

  localparam int CW = $clog2(DW) + 1;

  state_e         state_q, state_d;
  logic [2:0]     ctrl_q, ctrl_d, sel_q, sel_d;
  logic [RAW-1:0] wra_q, wra_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  rd1_q, rd1_d, rd2_q, rd2_d, num_q, num_d, shamt_q, shamt_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;

  logic           accept;
  logic [DW-1:0]  opa_slot, opb_slot, opa_in, opb_in, alu_y;

  // sel packing is {sA1, sA2, sB}; sA2 takes priority over sA1
  function automatic logic [DW-1:0] pick_a(input logic [2:0] sel, input logic [DW-1:0] rd1,
                                           input logic [DW-1:0] num, input logic [DW-1:0] shamt);
    return sel[1] ? rd1 : (sel[2] ? num : shamt);
  endfunction

  assign opa_slot = pick_a(sel_q, rd1_q, num_q, shamt_q);
  assign opb_slot = sel_q[0] ? rd2_q : num_q;
  assign opa_in   = pick_a(i_EXP_sel, i_EXP_rd1, i_EXP_num, i_EXP_shamt);
  assign opb_in   = i_EXP_sel[0] ? i_EXP_rd2 : i_EXP_num;

  exe_alu #(.DW(DW), .OPW(OPW)) u_alu (
    .op (op_q),
    .a  (opa_slot),
    .b  (opb_slot),
    .y  (alu_y)
  );

  assign o_EXP_valid = (state_q == ST_HOLD) || (state_q == ST_MDONE);
  assign o_EXP_ready = (state_q == ST_IDLE) || (o_EXP_valid && i_EXP_ready);
  assign accept      = i_EXP_valid && o_EXP_ready && !i_EXP_flush;

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    sel_d    = sel_q;
    wra_d    = wra_q;
    op_d     = op_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    num_d    = num_q;
    shamt_d  = shamt_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;

    case (state_q)
      ST_HOLD, ST_MDONE: if (i_EXP_ready) state_d = ST_IDLE;
      ST_MUL: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_MDONE;
      end
      default: ;
    endcase

    if (accept) begin
      ctrl_d  = i_EXP_ctrl;
      sel_d   = i_EXP_sel;
      wra_d   = i_EXP_WRA;
      op_d    = i_EXP_ALUop;
      rd1_d   = i_EXP_rd1;
      rd2_d   = i_EXP_rd2;
      num_d   = i_EXP_num;
      shamt_d = i_EXP_shamt;
      if (i_EXP_ALUop == OPW'(OP_MUL)) begin
        state_d  = ST_MUL;
        cnt_d    = CW'(DW);
        mcand_d  = opa_in;
        mplier_d = opb_in;
        prod_d   = '0;
      end else begin
        state_d = ST_HOLD;
      end
    end

    if (i_EXP_flush) state_d = ST_IDLE;
  end

  always_ff @(posedge i_EXP_clk or posedge i_EXP_rst) begin
    if (i_EXP_rst) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      sel_q    <= '0;
      wra_q    <= '0;
      op_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      num_q    <= '0;
      shamt_q  <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      sel_q    <= sel_d;
      wra_q    <= wra_d;
      op_q     <= op_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      num_q    <= num_d;
      shamt_q  <= shamt_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  // Everything downstream sees is zero unless a result is being offered
  assign o_EXP_ctrl   = o_EXP_valid ? ctrl_q : 3'b000;
  assign o_EXP_WRA    = o_EXP_valid ? wra_q : '0;
  assign o_EXP_rd2    = o_EXP_valid ? rd2_q : '0;
  assign o_EXP_ALUout = (state_q == ST_MDONE) ? prod_q :
                        (state_q == ST_HOLD)  ? alu_y  : '0;

endmodule

// File: tb/tb_exe_pipe.sv
// Scoreboard bench for exe_pipe: directed vectors push expectations, a monitor pops on each handshake.
module tb_exe_pipe;
  import exe_pkg::*;

  localparam int DW  = 32;
  localparam int RAW = 5;
  localparam int OPW = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_valid, i_flush, i_ready;
  logic [2:0]     i_ctrl, i_sel;
  logic [RAW-1:0] i_wra;
  logic [OPW-1:0] i_op;
  logic [DW-1:0]  i_rd1, i_rd2, i_num, i_shamt;
  logic           o_ready, o_valid;
  logic [2:0]     o_ctrl;
  logic [RAW-1:0] o_wra;
  logic [DW-1:0]  o_alu, o_rd2;

  logic           v16, ready_in16, o_ready16, o_valid16;
  logic [2:0]     o_ctrl16;
  logic [RAW-1:0] o_wra16;
  logic [15:0]    rd1_16, rd2_16, o_alu16, o_rd2_16;

  always #5 clk = ~clk;

  exe_pipe #(.DW(DW), .RAW(RAW), .OPW(OPW)) dut (
    .i_EXP_clk(clk), .i_EXP_rst(rst), .i_EXP_valid(i_valid), .o_EXP_ready(o_ready),
    .i_EXP_flush(i_flush), .i_EXP_ctrl(i_ctrl), .i_EXP_sel(i_sel), .i_EXP_WRA(i_wra),
    .i_EXP_ALUop(i_op), .i_EXP_rd1(i_rd1), .i_EXP_rd2(i_rd2), .i_EXP_num(i_num),
    .i_EXP_shamt(i_shamt), .o_EXP_valid(o_valid), .i_EXP_ready(i_ready),
    .o_EXP_ctrl(o_ctrl), .o_EXP_WRA(o_wra), .o_EXP_ALUout(o_alu), .o_EXP_rd2(o_rd2)
  );

  exe_pipe #(.DW(16), .RAW(RAW), .OPW(OPW)) dut16 (
    .i_EXP_clk(clk), .i_EXP_rst(rst), .i_EXP_valid(v16), .o_EXP_ready(o_ready16),
    .i_EXP_flush(1'b0), .i_EXP_ctrl(3'b010), .i_EXP_sel(3'b011), .i_EXP_WRA(5'd9),
    .i_EXP_ALUop(6'd12), .i_EXP_rd1(rd1_16), .i_EXP_rd2(rd2_16), .i_EXP_num(16'h0),
    .i_EXP_shamt(16'h0), .o_EXP_valid(o_valid16), .i_EXP_ready(ready_in16),
    .o_EXP_ctrl(o_ctrl16), .o_EXP_WRA(o_wra16), .o_EXP_ALUout(o_alu16), .o_EXP_rd2(o_rd2_16)
  );

  typedef struct {
    logic [2:0]     ctrl;
    logic [RAW-1:0] wra;
    logic [DW-1:0]  alu;
    logic [DW-1:0]  rd2;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: a handshake completes at the next rising edge when valid && ready
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (o_valid && i_ready) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got ALUout %h, expected no output", o_alu);
          end else begin
            mon_e = sb_q.pop_front();
            $display("out: ALUout=%h ctrl=%b WRA=%0d rd2=%h", o_alu, o_ctrl, o_wra, o_rd2);
            check("sb_alu", 64'(o_alu), 64'(mon_e.alu));
            check("sb_ctrl", 64'(o_ctrl), 64'(mon_e.ctrl));
            check("sb_wra", 64'(o_wra), 64'(mon_e.wra));
            check("sb_rd2", 64'(o_rd2), 64'(mon_e.rd2));
          end
        end else if (!o_valid) begin
          check("ctrl_when_invalid", 64'(o_ctrl), 64'd0);
        end
      end
    end
  end

  task automatic drive(input logic [OPW-1:0] op, input logic [2:0] sel, input logic [2:0] ctrl,
                       input logic [RAW-1:0] wra, input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                       input logic [DW-1:0] num, input logic [DW-1:0] shamt);
    i_valid = 1'b1; i_op = op; i_sel = sel; i_ctrl = ctrl; i_wra = wra;
    i_rd1 = rd1; i_rd2 = rd2; i_num = num; i_shamt = shamt;
  endtask

  // Holds the instruction until accepted; returns 1 time unit after the accepting edge
  task automatic issue(input logic [OPW-1:0] op, input logic [2:0] sel, input logic [2:0] ctrl,
                       input logic [RAW-1:0] wra, input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                       input logic [DW-1:0] num, input logic [DW-1:0] shamt,
                       input logic [DW-1:0] exp_alu, input bit push);
    bit done = 1'b0;
    drive(op, sel, ctrl, wra, rd1, rd2, num, shamt);
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (o_ready) begin
        if (push) sb_q.push_back(exp_t'{ctrl, wra, exp_alu, rd2});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    $display("issue: op=%0d sel=%b rd1=%h rd2=%h num=%h shamt=%h expect=%h", op, sel, rd1, rd2,
             num, shamt, exp_alu);
    if (!done) check("issue_timeout", 64'd0, 64'd1);
  endtask

  int cnt;
  int rises;

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_ready = 1'b1;
    i_valid = 1'b0; i_op = '0; i_sel = '0; i_ctrl = '0; i_wra = '0;
    i_rd1 = '0; i_rd2 = '0; i_num = '0; i_shamt = '0;
    v16 = 1'b0; ready_in16 = 1'b1; rd1_16 = '0; rd2_16 = '0;

    #12;
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_alu", 64'(o_alu), 64'd0);
    check("rst_ctrl_wra_rd2", {o_ctrl, o_wra, o_rd2}, 64'd0);
    check("rst16_ready", 64'(o_ready16), 64'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // ADD with one-cycle latency, then back to IDLE
    issue(6'd0, 3'b011, 3'b010, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0, 32'd12, 1'b1);
    @(negedge clk);
    check("add_latency_valid", 64'(o_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("add_then_idle_valid", 64'(o_valid), 64'd0);
    check("add_then_idle_ready", 64'(o_ready), 64'd1);
    @(posedge clk); #1;

    // Back-to-back directed vectors through the ALU and a short MUL
    issue(6'd1,  3'b011, 3'b010, 5'd1,  32'd5, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b1);
    issue(6'd2,  3'b011, 3'b100, 5'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'd0, 32'h00F0_1200, 1'b1);
    issue(6'd3,  3'b011, 3'b001, 5'd3,  32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'd0, 32'hFFF0_FF34, 1'b1);
    issue(6'd4,  3'b011, 3'b110, 5'd4,  32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'd0, 32'hFF00_ED34, 1'b1);
    issue(6'd5,  3'b100, 3'b111, 5'd5,  32'd0, 32'd0, 32'h0000_FFFF, 32'd0, 32'hFFFF_0000, 1'b1);
    issue(6'd6,  3'b011, 3'b011, 5'd6,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1, 1'b1);
    issue(6'd7,  3'b011, 3'b011, 5'd7,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1);
    issue(6'd8,  3'b000, 3'b101, 5'd8,  32'd0, 32'd0, 32'h0000_00AB, 32'h28, 32'h0000_AB00, 1'b1);
    issue(6'd9,  3'b001, 3'b001, 5'd9,  32'd0, 32'h8000_0000, 32'd0, 32'd4, 32'h0800_0000, 1'b1);
    issue(6'd10, 3'b011, 3'b010, 5'd10, 32'd4, 32'h8000_0000, 32'd0, 32'd0, 32'hF800_0000, 1'b1);
    issue(6'd11, 3'b000, 3'b100, 5'd11, 32'd0, 32'd0, 32'h0000_1234, 32'd0, 32'h1234_0000, 1'b1);
    issue(6'd13, 3'b011, 3'b111, 5'd12, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1);
    issue(6'd63, 3'b011, 3'b001, 5'd13, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1);
    issue(6'd0,  3'b110, 3'b010, 5'd14, 32'd100, 32'd9, 32'd23, 32'd50, 32'd123, 1'b1);
    issue(6'd12, 3'b100, 3'b001, 5'd15, 32'd0, 32'd0, 32'd7, 32'd0, 32'd49, 1'b1);
    issue(6'd0,  3'b011, 3'b010, 5'd16, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd1, 1'b1);
    @(posedge clk); #1;

    // MUL busy window and wrapped product
    issue(6'd12, 3'b011, 3'b001, 5'd17, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFD, 1'b1);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_ready) break;
      if (o_valid) check("mul_valid_early", 64'(o_valid), 64'd0);
      cnt++;
    end
    check("mul_busy_cycles", 64'(cnt), 64'd32);
    check("mul_valid", 64'(o_valid), 64'd1);
    @(posedge clk); #1;

    // Downstream stall with a pending new instruction
    i_ready = 1'b0;
    issue(6'd0, 3'b011, 3'b011, 5'd20, 32'd10, 32'd20, 32'd0, 32'd0, 32'd30, 1'b1);
    drive(6'd4, 3'b011, 3'b101, 5'd21, 32'h0000_00FF, 32'h0000_000F, 32'd0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(o_valid), 64'd1);
      check("stall_alu", 64'(o_alu), 64'd30);
      check("stall_ready", 64'(o_ready), 64'd0);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    issue(6'd4, 3'b011, 3'b101, 5'd21, 32'h0000_00FF, 32'h0000_000F, 32'd0, 32'd0, 32'h0000_00F0, 1'b1);
    @(negedge clk);
    check("no_bubble_valid", 64'(o_valid), 64'd1);
    @(posedge clk); #1;

    // Flush at the tenth MUL iteration, concurrent with a new instruction
    issue(6'd12, 3'b011, 3'b001, 5'd22, 32'd5, 32'd5, 32'd0, 32'd0, 32'd25, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    i_flush = 1'b1;
    drive(6'd0, 3'b011, 3'b010, 5'd23, 32'd1, 32'd1, 32'd0, 32'd0);
    @(posedge clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    check("flush_ready", 64'(o_ready), 64'd1);
    check("flush_valid", 64'(o_valid), 64'd0);
    rises = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_valid) rises++;
    end
    check("flush_valid_rises", 64'(rises), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a MUL
    issue(6'd12, 3'b011, 3'b001, 5'd24, 32'd9, 32'd9, 32'd0, 32'd0, 32'd81, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_ready", 64'(o_ready), 64'd1);
    check("mrst_valid", 64'(o_valid), 64'd0);
    check("mrst_alu", 64'(o_alu), 64'd0);
    check("mrst_ctrl_wra_rd2", {o_ctrl, o_wra, o_rd2}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(6'd0, 3'b011, 3'b110, 5'd25, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
    sb_q.push_back(exp_t'{3'b110, 5'd25, 32'd1, 32'd2});
    $display("issue: op=0 after reset release, expect=00000001");
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    check("post_rst_accept_valid", 64'(o_valid), 64'd1);
    @(posedge clk); #1;

    // DW=16 multiplier
    rd1_16 = 16'hFFFF; rd2_16 = 16'd3; v16 = 1'b1;
    @(negedge clk);
    check("dw16_idle_ready", 64'(o_ready16), 64'd1);
    @(posedge clk); #1;
    v16 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_ready16) break;
      cnt++;
    end
    $display("dw16 mul: busy=%0d valid=%0d ALUout=%h", cnt, o_valid16, o_alu16);
    check("dw16_busy_cycles", 64'(cnt), 64'd16);
    check("dw16_valid", 64'(o_valid16), 64'd1);
    check("dw16_alu", 64'(o_alu16), 64'h0000_FFFD);
    @(posedge clk); #1;

    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
